// File: rtl/lz4_buf_sched.sv
// Source-word scheduler for an LZ4 compression buffer: loads a word stream into the
// buffer with one registered write stage and arbitrates match/literal reads of the buffer RAM.
module lz4_buf_sched #(
  parameter int DICT_WORDS = 65535
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  input  logic        src_last,
  output logic        src_ready,
  output logic        compress_start,
  output logic        wr_req,
  output logic [31:0] idata,
  output logic        seg_done,
  output logic        compress_done,
  input  logic        buf_full,
  input  logic        fifo_empty,
  input  logic        m_req,
  input  logic [31:0] m_addr,
  output logic        m_gnt,
  input  logic        l_req,
  input  logic [31:0] l_addr,
  output logic        l_gnt,
  output logic        ram_rd,
  output logic [31:0] ram_abs_addr,
  input  logic        ram_ovalid,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {IDLE, START, LOAD, DRAIN, FIN} state_t;

  localparam logic [15:0] CNT_TOP = 16'(DICT_WORDS - 1);

  state_t      state_q, state_d;
  logic        wr_vld_q, wr_vld_d;
  logic [31:0] idata_q, idata_d;
  logic        last_pend_q, last_pend_d;
  logic [15:0] cnt_q, cnt_d;
  logic        outst_q, outst_d;
  logic        prio_l_q, prio_l_d;
  logic        arb_en;
  logic        rd_free;
  logic        xfer;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      wr_vld_q    <= 1'b0;
      idata_q     <= '0;
      last_pend_q <= 1'b0;
      cnt_q       <= '0;
      outst_q     <= 1'b0;
      prio_l_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_vld_q    <= wr_vld_d;
      idata_q     <= idata_d;
      last_pend_q <= last_pend_d;
      cnt_q       <= cnt_d;
      outst_q     <= outst_d;
      prio_l_q    <= prio_l_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_vld_d     = 1'b0;
    idata_d      = '0;
    last_pend_d  = 1'b0;
    cnt_d        = cnt_q;
    outst_d      = outst_q;
    prio_l_d     = prio_l_q;
    src_ready    = 1'b0;
    xfer         = 1'b0;
    m_gnt        = 1'b0;
    l_gnt        = 1'b0;
    ram_rd       = 1'b0;
    ram_abs_addr = '0;
    seg_done     = 1'b0;

    // A new grant may ride on the same cycle that retires the previous read.
    arb_en  = (state_q == LOAD) || (state_q == DRAIN);
    rd_free = !outst_q || ram_ovalid;
    if (arb_en && rd_free) begin
      if (m_req && (!l_req || !prio_l_q)) begin
        m_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end
    ram_rd = m_gnt || l_gnt;
    if (m_gnt) begin
      ram_abs_addr = m_addr;
      prio_l_d     = 1'b1;
    end else if (l_gnt) begin
      ram_abs_addr = l_addr;
      prio_l_d     = 1'b0;
    end
    if (ram_rd) begin
      outst_d = 1'b1;
    end else if (ram_ovalid) begin
      outst_d = 1'b0;
    end

    if (wr_vld_q) begin
      seg_done = (cnt_q == CNT_TOP);
      cnt_d    = seg_done ? 16'd0 : cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        // Once the last word is captured, stop accepting until its write has gone out.
        src_ready   = !buf_full && !last_pend_q;
        xfer        = src_valid && src_ready;
        wr_vld_d    = xfer;
        idata_d     = xfer ? src_data : 32'd0;
        last_pend_d = xfer && src_last;
        if (last_pend_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !outst_d) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign compress_start = (state_q == START);
  assign compress_done  = (state_q == FIN);
  assign done           = (state_q == FIN);
  assign busy           = (state_q != IDLE);
  assign wr_req         = wr_vld_q;
  assign idata          = idata_q;
  assign word_cnt       = cnt_q;

endmodule

// File: tb/tb_lz4_buf_sched.sv
// Bench for lz4_buf_sched: directed job sequences with a write scoreboard and a
// table of arbitration vectors, run on a DICT_WORDS=8 instance.
module tb_lz4_buf_sched;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rstN, start, src_valid, src_last, src_ready;
  logic [31:0] src_data;
  logic        compress_start, wr_req, seg_done, compress_done;
  logic [31:0] idata;
  logic        buf_full, fifo_empty;
  logic        m_req, l_req, m_gnt, l_gnt;
  logic [31:0] m_addr, l_addr;
  logic        ram_rd, ram_ovalid;
  logic [31:0] ram_abs_addr;
  logic        busy, done;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  lz4_buf_sched #(.DICT_WORDS(DW)) dut (
    .clk(clk), .rstN(rstN), .start(start),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .compress_start(compress_start), .wr_req(wr_req), .idata(idata), .seg_done(seg_done),
    .compress_done(compress_done), .buf_full(buf_full), .fifo_empty(fifo_empty),
    .m_req(m_req), .m_addr(m_addr), .m_gnt(m_gnt),
    .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt),
    .ram_rd(ram_rd), .ram_abs_addr(ram_abs_addr), .ram_ovalid(ram_ovalid),
    .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic        seg;
  } wr_t;
  wr_t sb[$];
  int  seg_cnt = 0;
  logic rd_pend = 1'b0;

  typedef struct packed {
    logic        m, l, ov, mg, lg, rd;
    logic [31:0] addr;
  } arb_vec_t;
  arb_vec_t tbl [16];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] d);
    wr_t e;
    seg_cnt++;
    e.data = d;
    e.seg  = (seg_cnt == DW);
    if (e.seg) seg_cnt = 0;
    sb.push_back(e);
  endtask

  task automatic start_job();
    start = 1'b1;
    smp();
    chk("idle_no_cs", {compress_start, busy}, 2'b00);
    tick();
    start = 1'b0;
    seg_cnt = 0;
    smp();
    chk("start_pulse", {compress_start, busy, src_ready}, 3'b110);
    tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    src_valid = 1'b1;
    src_data  = d;
    src_last  = last;
    smp();
    chk("src_ready", src_ready, 1'b1);
    push_word(d);
    tick();
  endtask

  task automatic finish_job(input int extra);
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_data  = '0;
    smp();
    chk("last_wr_cycle", {src_ready, busy, compress_done}, 3'b010);
    tick();
    for (int k = 0; k < extra; k++) begin
      smp();
      chk("drain_wait", {compress_done, busy, src_ready}, 3'b010);
      tick();
    end
    fifo_empty = 1'b1;
    smp();
    chk("drain_exit", {compress_done, busy}, 2'b01);
    tick();
    fifo_empty = 1'b0;
    smp();
    chk("fin_pulse", {compress_done, done, busy}, 3'b111);
    tick();
    smp();
    chk("back_idle", {compress_done, done, busy}, 3'b000);
    chk("sb_empty", sb.size(), 0);
    tick();
  endtask

  // Write scoreboard and RAM read-overlap watch.
  always @(negedge clk) begin
    if (!rstN) begin
      rd_pend = 1'b0;
    end else begin
      if (wr_req) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wr_unexpected: got write %0h expected none", idata);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_data", idata, e.data);
          chk("seg_done", seg_done, e.seg);
        end
      end else begin
        chk("no_wr", {seg_done, idata}, 33'd0);
      end
      if (ram_rd) begin
        chk("rd_overlap", rd_pend && !ram_ovalid, 1'b0);
        rd_pend = 1'b1;
      end else if (ram_ovalid) begin
        rd_pend = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  function automatic arb_vec_t av(input logic m, l, ov, mg, lg, rd, input logic [31:0] a);
    arb_vec_t v;
    v = '{m: m, l: l, ov: ov, mg: mg, lg: lg, rd: rd, addr: a};
    return v;
  endfunction

  initial begin
    tbl[0]  = av(1, 1, 0, 1, 0, 1, 32'h12);
    tbl[1]  = av(1, 1, 0, 0, 0, 0, 32'h0);
    tbl[2]  = av(1, 1, 1, 0, 1, 1, 32'h34);
    tbl[3]  = av(1, 1, 0, 0, 0, 0, 32'h0);
    tbl[4]  = av(1, 1, 1, 1, 0, 1, 32'h12);
    tbl[5]  = av(1, 1, 0, 0, 0, 0, 32'h0);
    tbl[6]  = av(1, 1, 1, 0, 1, 1, 32'h34);
    tbl[7]  = av(0, 0, 1, 0, 0, 0, 32'h0);
    tbl[8]  = av(0, 0, 1, 0, 0, 0, 32'h0);
    tbl[9]  = av(0, 1, 0, 0, 1, 1, 32'h34);
    tbl[10] = av(0, 1, 0, 0, 0, 0, 32'h0);
    tbl[11] = av(0, 0, 1, 0, 0, 0, 32'h0);
    tbl[12] = av(1, 0, 0, 1, 0, 1, 32'h12);
    tbl[13] = av(0, 0, 1, 0, 0, 0, 32'h0);
    tbl[14] = av(1, 1, 0, 0, 1, 1, 32'h34);
    tbl[15] = av(0, 0, 1, 0, 0, 0, 32'h0);

    rstN = 1'b0; start = 1'b0; src_valid = 1'b1; src_data = 32'hFFFF_FFFF; src_last = 1'b0;
    buf_full = 1'b0; fifo_empty = 1'b1; m_req = 1'b1; l_req = 1'b1;
    m_addr = 32'h12; l_addr = 32'h34; ram_ovalid = 1'b0;

    // Reset state, then the very first start right after release.
    tick();
    smp();
    chk("rst_ctrl", {compress_start, wr_req, seg_done, compress_done, m_gnt, l_gnt, ram_rd,
                     busy, done, src_ready}, 10'd0);
    chk("rst_data", {idata, ram_abs_addr, word_cnt}, 80'd0);
    tick();
    rstN = 1'b1;
    start = 1'b1;
    smp();
    chk("idle_ctrl", {compress_start, m_gnt, l_gnt, ram_rd, busy, src_ready}, 6'd0);
    tick();
    start = 1'b0; src_valid = 1'b0; m_req = 1'b0; l_req = 1'b0; fifo_empty = 1'b0;
    seg_cnt = 0;
    smp();
    chk("first_start", {compress_start, busy}, 2'b11);
    tick();
    smp();
    chk("cs_one_cycle", {compress_start, word_cnt}, 17'd0);

    // Basic four-word job.
    tick();
    send_word(32'h11, 1'b0);
    send_word(32'h22, 1'b0);
    send_word(32'h33, 1'b0);
    send_word(32'h44, 1'b1);
    finish_job(2);
    chk("wc_basic", word_cnt, 16'd4);

    // Back-pressure with a single skid write.
    start_job();
    send_word(32'hA0, 1'b0);
    src_data = 32'hA1; src_valid = 1'b1; buf_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("bf_ready", src_ready, 1'b0);
      tick();
    end
    buf_full = 1'b0;
    send_word(32'hA1, 1'b0);
    send_word(32'hA2, 1'b1);
    finish_job(0);
    chk("wc_bf", word_cnt, 16'd3);

    // Segment wrap at DICT_WORDS.
    start_job();
    for (int i = 0; i < 10; i++) send_word(32'h100 + i, i == 9);
    finish_job(0);
    chk("wc_wrap", word_cnt, 16'd2);

    // Fresh reset so arbitration starts from match priority.
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    start_job();
    for (int i = 0; i < 16; i++) begin
      m_req = tbl[i].m; l_req = tbl[i].l; ram_ovalid = tbl[i].ov;
      smp();
      chk($sformatf("arb_gnt%0d", i), {m_gnt, l_gnt, ram_rd}, {tbl[i].mg, tbl[i].lg, tbl[i].rd});
      chk($sformatf("arb_addr%0d", i), ram_abs_addr, tbl[i].addr);
      tick();
    end
    m_req = 1'b0; l_req = 1'b0; ram_ovalid = 1'b0;
    send_word(32'h55, 1'b1);
    finish_job(0);

    // Last word while a read is outstanding: DRAIN waits for ram_ovalid.
    start_job();
    src_valid = 1'b1; src_data = 32'h99; src_last = 1'b1; m_req = 1'b1;
    smp();
    chk("dr_rdy", src_ready, 1'b1);
    chk("dr_gnt", {m_gnt, ram_rd, ram_abs_addr}, {2'b11, 32'h12});
    push_word(32'h99);
    tick();
    m_req = 1'b0; src_valid = 1'b0; src_last = 1'b0; fifo_empty = 1'b1;
    smp();
    chk("dr_loadwr", {src_ready, busy, compress_done}, 3'b010);
    tick();
    for (int k = 0; k < 2; k++) begin
      smp();
      chk("dr_hold", {compress_done, busy}, 2'b01);
      tick();
    end
    ram_ovalid = 1'b1;
    smp();
    chk("dr_ov", compress_done, 1'b0);
    tick();
    ram_ovalid = 1'b0;
    smp();
    chk("dr_fin", {compress_done, done}, 2'b11);
    tick();
    fifo_empty = 1'b0;
    smp();
    chk("dr_idle", busy, 1'b0);
    chk("dr_sb", sb.size(), 0);
    tick();

    // Reset in the middle of LOAD abandons the job.
    start_job();
    send_word(32'h61, 1'b0);
    send_word(32'h62, 1'b0);
    send_word(32'h63, 1'b0);
    src_valid = 1'b0;
    rstN = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_ctrl", {compress_start, wr_req, seg_done, compress_done, m_gnt, l_gnt, ram_rd,
                         busy, done, src_ready}, 10'd0);
    chk("rst_mid_data", {idata, ram_abs_addr, word_cnt}, 80'd0);
    for (int k = 0; k < 2; k++) begin
      smp();
      chk("rst_no_cd", {compress_done, done, busy}, 3'b000);
      tick();
    end
    rstN = 1'b1;
    start_job();
    chk("wc_restart", word_cnt, 16'd0);
    send_word(32'h71, 1'b0);
    send_word(32'h72, 1'b1);
    finish_job(1);
    chk("wc_after_rst", word_cnt, 16'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lz4_buf_sched.md
LZ4_BUF_SCHED -- requirements
Module: lz4_buf_sched

Interface
- REQ-001 Parameter DICT_WORDS, default 65535, sets the number of source words accepted per segment before seg_done pulses.
- REQ-002 Port clk, input, 1: single clock; all logic on rising edge.
- REQ-003 Port rstN, input, 1: asynchronous active-low reset.
- REQ-004 Port start, input, 1: one-cycle pulse that begins a compression job.
- REQ-005 Ports src_valid (input, 1), src_data (input, 32), src_last (input, 1) and src_ready (output, 1) form the source word stream with a valid/ready handshake.
- REQ-006 Outputs to the buffer: compress_start (1), wr_req (1), idata (32), seg_done (1), compress_done (1); inputs from the buffer: buf_full (1), fifo_empty (1).
- REQ-007 Match requester: m_req (input, 1), m_addr (input, 32), m_gnt (output, 1).
- REQ-008 Literal requester: l_req (input, 1), l_addr (input, 32), l_gnt (output, 1).
- REQ-009 Buffer RAM port: ram_rd (output, 1), ram_abs_addr (output, 32), ram_ovalid (input, 1).
- REQ-010 Status outputs: busy (1), done (1), word_cnt (16).

Function
- REQ-011 FSM states: IDLE, START, LOAD, DRAIN, FIN.
- REQ-012 IDLE: start=1 moves to START next cycle; start is ignored in every other state.
- REQ-013 START: compress_start=1 for exactly one cycle, word_cnt cleared, then LOAD.
- REQ-014 LOAD: src_ready = !buf_full; a transfer occurs when src_valid && src_ready.
- REQ-015 On each transfer, the cycle after it has wr_req=1 and idata=src_data, i.e. one-cycle registered latency.
- REQ-016 Cycles without a transfer have wr_req=0 and idata=0.
- REQ-017 If buf_full rises while a registered write is pending, that write is still issued; the buffer tolerates one write of skid.
- REQ-018 word_cnt increments per transfer; when it reaches DICT_WORDS, seg_done pulses one cycle coincident with that write and word_cnt wraps to 0.
- REQ-019 A transfer with src_last=1 moves LOAD to DRAIN after its write issues.
- REQ-020 DRAIN: src_ready=0; stay until fifo_empty=1 and no RAM read is outstanding, then FIN.
- REQ-021 FIN: compress_done=1 and done=1 for one cycle, then IDLE.
- REQ-022 busy=1 in every state except IDLE.
- REQ-023 RAM arbitration is active in LOAD and DRAIN only; m_gnt and l_gnt are 0 in all other states.
- REQ-024 At most one RAM read may be outstanding at a time.
- REQ-025 A grant is issued only when no read is outstanding; the grant cycle drives ram_rd=1 and ram_abs_addr = address of the granted requester.
- REQ-026 ram_rd and m_gnt/l_gnt are one-cycle pulses; ram_abs_addr is 0 when ram_rd=0.
- REQ-027 The outstanding flag sets on a grant and clears on ram_ovalid; a grant may issue in the same cycle the flag clears.
- REQ-028 Arbitration is round-robin: when both requesters assert, the one not granted last wins; after reset the match requester has priority.
- REQ-029 A requester holds req and its address stable until granted; a dropped request is simply not served.
- REQ-030 ram_ovalid with no read outstanding is ignored.

Reset
- REQ-031 rstN=0 asynchronously forces state IDLE and sets all outputs to 0, except src_ready which reads 0 in IDLE.
- REQ-032 Reset also clears word_cnt, the outstanding flag and the round-robin pointer (match first).
- REQ-033 Reset asserted mid-job abandons the job with no compress_done.
- REQ-034 After reset deassertion, the first start is accepted on the next rising edge.

Verification
- REQ-035 Start pulse, 4 words (last on the 4th), buf_full=0 -> compress_start one cycle; wr_req 4 cycles carrying those words at 1-cycle lag; word_cnt=4; compress_done one cycle after fifo_empty=1.
- REQ-036 buf_full held 1 for 5 cycles during LOAD -> src_ready=0 and no wr_req beyond the single skid write; flow resumes the cycle after buf_full=0.
- REQ-037 DICT_WORDS=8, 10 words streamed -> seg_done on the 8th write only; word_cnt ends at 2.
- REQ-038 m_req and l_req held together with ram_ovalid returned 2 cycles after each ram_rd -> grants alternate M, L, M, L; never two ram_rd without an intervening ram_ovalid; ram_abs_addr matches the granted requester's address (e.g. 32'h12 for M).
- REQ-039 Last word sent while a read is outstanding and fifo_empty=1 -> FSM stays in DRAIN until ram_ovalid, then FIN.
- REQ-040 rstN pulsed low in LOAD after 3 words -> all outputs 0 immediately; no compress_done; a new start then runs normally with word_cnt counting from 0.
